// File: rtl/tower_decoding_if.sv
// rtl/tower_decoding_if.sv - stream and status bundle for the tower decoder
//
// Purpose: groups the encoded-word input stream, the decoded-counter output
// stream and the sticky error flag of tower_decoding.
// Signals:
//   In_Data[31:0]     encoded word (bitmap or slice word)
//   In_Valid          In_Data is valid
//   In_Ready          decoder accepts In_Data this cycle
//   Out_Counter[31:0] reconstructed counter value
//   Out_Index[4:0]    index of Out_Counter
//   Out_Valid         Out_Counter/Out_Index are valid
//   Out_Ready         downstream accepts the output word
//   Out_Last          high with the counter at index NUM_COUNTER-1
//   Error             sticky format-error flag
// Modports: master = stream source/sink side, slave = decoder side.

interface tower_decoding_if;
  logic [31:0] In_Data;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] Out_Counter;
  logic [4:0]  Out_Index;
  logic        Out_Valid;
  logic        Out_Ready;
  logic        Out_Last;
  logic        Error;

  modport master (
    output In_Data, In_Valid, Out_Ready,
    input  In_Ready, Out_Counter, Out_Index, Out_Valid, Out_Last, Error
  );

  modport slave (
    input  In_Data, In_Valid, Out_Ready,
    output In_Ready, Out_Counter, Out_Index, Out_Valid, Out_Last, Error
  );
endinterface

// File: rtl/tower_decoding.sv
// rtl/tower_decoding.sv - streaming decoder for the tower-encoded counter format
//
// Purpose: rebuilds a frame of NUM_COUNTER 32-bit counters from a word stream
// made of one presence bitmap followed by per-counter slice words (lowest
// slice first, bit 31 = continue). Counters leave in ascending index order.
// Ports:
//   Clk    clock, rising edge
//   Reset  synchronous active-high reset
//   bus    tower_decoding_if.slave (input stream, output stream, Error)
// Parameters:
//   NUM_COUNTER  counters per frame (1..32)
//   NUM_SLICE    maximum slices per counter (2 or 4), slice width 32/NUM_SLICE
//   THRESHOLD    smallest legal value of a counter present in the stream

module tower_decoding #(
  parameter int NUM_COUNTER = 10,
  parameter int NUM_SLICE   = 2,
  parameter int THRESHOLD   = 20
) (
  input logic             Clk,
  input logic             Reset,
  tower_decoding_if.slave bus
);

  localparam int          SLICE_W     = 32 / NUM_SLICE;
  localparam logic [1:0]  K_LAST      = 2'(NUM_SLICE - 1);
  localparam logic [4:0]  IDX_LAST    = 5'(NUM_COUNTER - 1);
  // Bits at or above NUM_COUNTER never get looked at; masking keeps the
  // register contents meaningful. For 32 counters the shift wraps to 0 and
  // the subtraction yields all ones.
  localparam logic [31:0] BITMAP_MASK = (32'd1 << NUM_COUNTER) - 32'd1;

  typedef enum logic [1:0] {
    S_HDR,
    S_SCAN,
    S_SLICE,
    S_EMIT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_bitmap;
  logic [4:0]  r_idx;
  logic [1:0]  r_k;
  logic [31:0] r_acc;
  logic        r_in_ready;
  logic [31:0] r_out_counter;
  logic [4:0]  r_out_index;
  logic        r_out_valid;
  logic        r_out_last;
  logic        r_error;

  logic [31:0] w_bitmap_nxt;
  logic [4:0]  w_idx_nxt;
  logic [1:0]  w_k_nxt;
  logic [31:0] w_acc_nxt;
  logic        w_in_ready_nxt;
  logic [31:0] w_out_counter_nxt;
  logic [4:0]  w_out_index_nxt;
  logic        w_out_valid_nxt;
  logic        w_out_last_nxt;
  logic        w_error_nxt;

  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_cont;
  logic [31:0] w_payload;
  logic [4:0]  w_shift;
  logic [31:0] w_acc_merged;
  logic        w_is_last;
  logic        w_unused_bits;

  assign w_in_fire    = bus.In_Valid && r_in_ready;
  assign w_out_fire   = r_out_valid && bus.Out_Ready;
  assign w_cont       = bus.In_Data[31];
  assign w_payload    = 32'(bus.In_Data[SLICE_W-1:0]);
  assign w_shift      = 5'(r_k * SLICE_W);
  // Accumulator with the incoming slice placed at its layer position.
  assign w_acc_merged = r_acc | (w_payload << w_shift);
  assign w_is_last    = (r_idx == IDX_LAST);
  // Bits between the payload and the continue flag carry no information.
  assign w_unused_bits = ^bus.In_Data[30:SLICE_W];

  assign bus.In_Ready    = r_in_ready;
  assign bus.Out_Counter = r_out_counter;
  assign bus.Out_Index   = r_out_index;
  assign bus.Out_Valid   = r_out_valid;
  assign bus.Out_Last    = r_out_last;
  assign bus.Error       = r_error;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_HDR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_bitmap_nxt      = r_bitmap;
    w_idx_nxt         = r_idx;
    w_k_nxt           = r_k;
    w_acc_nxt         = r_acc;
    w_out_counter_nxt = r_out_counter;
    w_out_index_nxt   = r_out_index;
    w_out_valid_nxt   = r_out_valid;
    w_out_last_nxt    = r_out_last;
    w_error_nxt       = r_error;

    case (r_state)
      S_HDR: begin
        if (w_in_fire) begin
          w_bitmap_nxt = bus.In_Data & BITMAP_MASK;
          w_idx_nxt    = 5'd0;
          w_state_nxt  = S_SCAN;
        end
      end

      S_SCAN: begin
        if (!r_bitmap[r_idx]) begin
          // Absent counter: emit a zero straight away.
          w_out_counter_nxt = 32'd0;
          w_out_index_nxt   = r_idx;
          w_out_valid_nxt   = 1'b1;
          w_out_last_nxt    = w_is_last;
          w_state_nxt       = S_EMIT;
        end else begin
          w_acc_nxt   = 32'd0;
          w_k_nxt     = 2'd0;
          w_state_nxt = S_SLICE;
        end
      end

      S_SLICE: begin
        if (w_in_fire) begin
          if (w_cont && (r_k != K_LAST)) begin
            w_acc_nxt = w_acc_merged;
            w_k_nxt   = r_k + 2'd1;
          end else begin
            // A continue flag on the top slice is a format error; the
            // layers beyond it are not read, so the next word starts the
            // following counter (or the next frame).
            w_out_counter_nxt = w_acc_merged;
            w_out_index_nxt   = r_idx;
            w_out_valid_nxt   = 1'b1;
            w_out_last_nxt    = w_is_last;
            if (w_cont || (w_acc_merged < 32'(THRESHOLD))) begin
              w_error_nxt = 1'b1;
            end
            w_state_nxt = S_EMIT;
          end
        end
      end

      S_EMIT: begin
        if (w_out_fire) begin
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
          if (w_is_last) begin
            w_state_nxt = S_HDR;
          end else begin
            w_idx_nxt   = r_idx + 5'd1;
            w_state_nxt = S_SCAN;
          end
        end
      end

      default: begin
        w_state_nxt = S_HDR;
      end
    endcase

    // Ready is registered so that it reads 0 during reset and always
    // matches the state the decoder is about to be in.
    w_in_ready_nxt = (w_state_nxt == S_HDR) || (w_state_nxt == S_SLICE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_bitmap      <= 32'd0;
      r_idx         <= 5'd0;
      r_k           <= 2'd0;
      r_acc         <= 32'd0;
      r_in_ready    <= 1'b0;
      r_out_counter <= 32'd0;
      r_out_index   <= 5'd0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_bitmap      <= w_bitmap_nxt;
      r_idx         <= w_idx_nxt;
      r_k           <= w_k_nxt;
      r_acc         <= w_acc_nxt;
      r_in_ready    <= w_in_ready_nxt;
      r_out_counter <= w_out_counter_nxt;
      r_out_index   <= w_out_index_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_last    <= w_out_last_nxt;
      r_error       <= w_error_nxt;
    end
  end

endmodule

// File: tb/tb_tower_decoding.sv
// tb/tb_tower_decoding.sv - directed self-checking bench for tower_decoding

module tb_tower_decoding;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] words_q[$];
  logic [37:0] exp_q[$];   // {last, index[4:0], counter[31:0]}

  tower_decoding_if bus();

  tower_decoding #(
    .NUM_COUNTER(4),
    .NUM_SLICE  (2),
    .THRESHOLD  (20)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic expect_out(input int idx, input logic [31:0] val, input logic last);
    exp_q.push_back({last, 5'(idx), val});
  endtask

  // Drives words_q and collects outputs against exp_q. rdy_mode 0: Out_Ready
  // held high; 1: Out_Ready toggles every cycle starting low.
  task automatic run_stream(input int rdy_mode, input int exp_consumed);
    int          wi;
    int          no;
    int          cyc;
    logic        stalled;
    logic [31:0] h_cnt;
    logic [4:0]  h_idx;
    logic [37:0] e;
    wi = 0; no = 0; cyc = 0; stalled = 1'b0; h_cnt = '0; h_idx = '0;
    while ((cyc < 400) &&
           ((exp_q.size() > 0) ? (no < exp_q.size()) : (wi < words_q.size()))) begin
      @(negedge clk);
      bus.In_Valid  = (wi < words_q.size());
      bus.In_Data   = (wi < words_q.size()) ? words_q[wi] : 32'd0;
      bus.Out_Ready = (rdy_mode == 0) ? 1'b1 : cyc[0];
      #1;
      if (stalled) begin
        check("hold_valid", 32'(bus.Out_Valid), 32'd1);
        check("hold_counter", bus.Out_Counter, h_cnt);
        check("hold_index", 32'(bus.Out_Index), 32'(h_idx));
      end
      if (bus.Out_Valid && !bus.Out_Ready) begin
        check("stall_in_ready", 32'(bus.In_Ready), 32'd0);
        stalled = 1'b1;
        h_cnt   = bus.Out_Counter;
        h_idx   = bus.Out_Index;
      end else begin
        stalled = 1'b0;
      end
      if (bus.Out_Valid && bus.Out_Ready) begin
        if (no < exp_q.size()) begin
          e = exp_q[no];
          check("out_index", 32'(bus.Out_Index), 32'(e[36:32]));
          check("out_counter", bus.Out_Counter, e[31:0]);
          check("out_last", 32'(bus.Out_Last), 32'(e[37]));
        end else begin
          check("extra_out", 32'(no), 32'(exp_q.size()));
        end
        no++;
      end
      if (bus.In_Valid && bus.In_Ready) wi++;
      cyc++;
    end
    check("outputs_seen", 32'(no), 32'(exp_q.size()));
    check("consumed", 32'(wi), 32'(exp_consumed));
    @(negedge clk);
    bus.In_Valid  = 1'b0;
    bus.In_Data   = 32'd0;
    bus.Out_Ready = 1'b1;
  endtask

  initial begin
    bus.In_Valid  = 1'b0;
    bus.In_Data   = 32'd0;
    bus.Out_Ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.In_Ready), 32'd0);
    check("rst_out_valid", 32'(bus.Out_Valid), 32'd0);
    check("rst_out_counter", bus.Out_Counter, 32'd0);
    check("rst_out_index", 32'(bus.Out_Index), 32'd0);
    check("rst_out_last", 32'(bus.Out_Last), 32'd0);
    check("rst_error", 32'(bus.Error), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("hdr_ready", 32'(bus.In_Ready), 32'd1);

    // Mixed present/absent counters, one two-slice counter.
    words_q = '{32'h5, 32'h19, 32'h8000_0034, 32'h1};
    exp_q.delete();
    expect_out(0, 32'd25, 1'b0);
    expect_out(1, 32'd0, 1'b0);
    expect_out(2, 32'h0001_0034, 1'b0);
    expect_out(3, 32'd0, 1'b1);
    run_stream(0, 4);
    check("t1_error", 32'(bus.Error), 32'd0);

    // Empty bitmap: four zeros, one word taken, the spare word left alone.
    words_q = '{32'h0, 32'hFFFF_FFFF};
    exp_q.delete();
    for (int i = 0; i < 4; i++) expect_out(i, 32'd0, (i == 3));
    run_stream(0, 1);
    check("t2_error", 32'(bus.Error), 32'd0);

    // All present, backpressure toggling.
    words_q = '{32'hF, 32'h64, 32'h64, 32'h64, 32'h64};
    exp_q.delete();
    for (int i = 0; i < 4; i++) expect_out(i, 32'd100, (i == 3));
    run_stream(1, 5);
    check("t3_error", 32'(bus.Error), 32'd0);

    // Below threshold.
    words_q = '{32'h1, 32'h5};
    exp_q.delete();
    expect_out(0, 32'd5, 1'b0);
    for (int i = 1; i < 4; i++) expect_out(i, 32'd0, (i == 3));
    run_stream(0, 2);
    check("t4_error", 32'(bus.Error), 32'd1);

    // Error stays set across a clean frame.
    words_q = '{32'h0};
    exp_q.delete();
    for (int i = 0; i < 4; i++) expect_out(i, 32'd0, (i == 3));
    run_stream(0, 1);
    check("t4_error_sticky", 32'(bus.Error), 32'd1);

    // Continue flag on the top slice; next word is a new bitmap.
    words_q = '{32'h2, 32'h8000_0001, 32'h8000_0002, 32'h8, 32'h15};
    exp_q.delete();
    expect_out(0, 32'd0, 1'b0);
    expect_out(1, 32'h0002_0001, 1'b0);
    expect_out(2, 32'd0, 1'b0);
    expect_out(3, 32'd0, 1'b1);
    expect_out(0, 32'd0, 1'b0);
    expect_out(1, 32'd0, 1'b0);
    expect_out(2, 32'd0, 1'b0);
    expect_out(3, 32'd21, 1'b1);
    run_stream(0, 5);
    check("t5_error", 32'(bus.Error), 32'd1);

    // Reset in the middle of a frame.
    words_q = '{32'h3, 32'h8000_0010};
    exp_q.delete();
    run_stream(0, 2);
    check("t6_no_out", 32'(bus.Out_Valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_error", 32'(bus.Error), 32'd0);
    check("t6_rst_valid", 32'(bus.Out_Valid), 32'd0);
    words_q = '{32'h1, 32'h30};
    exp_q.delete();
    expect_out(0, 32'd48, 1'b0);
    for (int i = 1; i < 4; i++) expect_out(i, 32'd0, (i == 3));
    run_stream(0, 2);
    check("t6_error", 32'(bus.Error), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
